// File: rtl/park_lane_ctrl.sv
// Parking lane controller: debounced entry/exit buttons, token issue/redeem table,
// occupancy tracking and timed entry/exit barriers.
module park_lane_ctrl #(
    parameter int unsigned CAPACITY    = 8,
    parameter int unsigned TOKEN_W     = 5,
    parameter int unsigned DB_CYCLES   = 16,
    parameter int unsigned GATE_CYCLES = 8
) (
    input  logic                          clk_50MHz,
    input  logic                          reset,
    input  logic                          entry_sensor,
    input  logic                          exit_sensor,
    input  logic                          entry_btn_raw,
    input  logic                          exit_btn_raw,
    input  logic [TOKEN_W-1:0]            token_input,
    output logic [2:0]                    state,
    output logic [TOKEN_W-1:0]            token_code,
    output logic [$clog2(CAPACITY+1)-1:0] occupancy,
    output logic                          full,
    output logic                          empty,
    output logic                          entry_gate,
    output logic                          exit_gate,
    output logic                          deny
);

    localparam int unsigned OCC_W = $clog2(CAPACITY + 1);
    localparam int unsigned IDX_W = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
    localparam int unsigned DB_W  = $clog2(DB_CYCLES + 1);
    localparam int unsigned TMR_W = $clog2(GATE_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ENTRY_CHECK = 3'd1,
        ENTRY_OPEN  = 3'd2,
        EXIT_CHECK  = 3'd3,
        EXIT_OPEN   = 3'd4,
        DENY        = 3'd5
    } state_t;

    state_t cur_state, next_state;

    // Button conditioning, index 0 = entry, 1 = exit
    logic [1:0]      btn_raw, sync1, sync2, db_level, db_prev, press;
    logic [DB_W-1:0] db_cnt [2];

    assign btn_raw = {exit_btn_raw, entry_btn_raw};

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            db_prev <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            db_prev <= db_level;
            for (int i = 0; i < 2; i++) begin
                if (!sync2[i])
                    db_cnt[i] <= '0;
                else if (db_cnt[i] != DB_W'(DB_CYCLES))
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) db_level[i] = (db_cnt[i] == DB_W'(DB_CYCLES));
    end

    assign press = db_level & ~db_prev;

    // Token table and parallel lookups
    logic               slot_valid [CAPACITY];
    logic [TOKEN_W-1:0] slot_tok   [CAPACITY];
    logic [TOKEN_W-1:0] gen, gen_plus, gen_next;
    logic               cand_used, exit_hit, has_free;
    logic [IDX_W-1:0]   exit_idx, free_idx;
    logic [TMR_W-1:0]   tmr;
    logic               tbl_wr, tbl_clr, gen_inc, tmr_load;

    assign gen_plus = gen + TOKEN_W'(1);
    assign gen_next = (gen_plus == '0) ? TOKEN_W'(1) : gen_plus;

    always_comb begin
        cand_used = 1'b0;
        exit_hit  = 1'b0;
        exit_idx  = '0;
        has_free  = 1'b0;
        free_idx  = '0;
        for (int i = 0; i < CAPACITY; i++) begin
            if (slot_valid[i] && slot_tok[i] == gen)
                cand_used = 1'b1;
            if (slot_valid[i] && slot_tok[i] == token_input && token_input != '0) begin
                exit_hit = 1'b1;
                exit_idx = IDX_W'(i);
            end
            if (!slot_valid[i] && !has_free) begin
                has_free = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign full  = (occupancy == OCC_W'(CAPACITY));
    assign empty = (occupancy == '0);
    assign state = cur_state;

    always_ff @(posedge clk_50MHz) begin
        if (reset) cur_state <= IDLE;
        else       cur_state <= next_state;
    end

    // Next-state and table/timer control strobes
    always_comb begin
        next_state = cur_state;
        tbl_wr     = 1'b0;
        tbl_clr    = 1'b0;
        gen_inc    = 1'b0;
        tmr_load   = 1'b0;
        case (cur_state)
            IDLE: begin
                if (press[1] && exit_sensor) begin
                    next_state = EXIT_CHECK;
                end else if (press[0] && entry_sensor) begin
                    if (full) begin
                        next_state = DENY;
                        tmr_load   = 1'b1;
                    end else begin
                        next_state = ENTRY_CHECK;
                    end
                end
            end
            ENTRY_CHECK: begin
                if (gen == '0 || cand_used) begin
                    gen_inc = 1'b1;
                end else if (has_free) begin
                    tbl_wr     = 1'b1;
                    gen_inc    = 1'b1;
                    tmr_load   = 1'b1;
                    next_state = ENTRY_OPEN;
                end else begin
                    tmr_load   = 1'b1;
                    next_state = DENY;
                end
            end
            ENTRY_OPEN: begin
                if (tmr == '0 && !entry_sensor) next_state = IDLE;
            end
            EXIT_CHECK: begin
                tmr_load = 1'b1;
                if (exit_hit) begin
                    tbl_clr    = 1'b1;
                    next_state = EXIT_OPEN;
                end else begin
                    next_state = DENY;
                end
            end
            EXIT_OPEN: begin
                if (tmr == '0 && !exit_sensor) next_state = IDLE;
            end
            DENY: begin
                if (tmr == '0) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath registers; the timer counts the remaining cycles after the current one
    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            for (int i = 0; i < CAPACITY; i++) begin
                slot_valid[i] <= 1'b0;
                slot_tok[i]   <= '0;
            end
            gen        <= TOKEN_W'(1);
            token_code <= '0;
            occupancy  <= '0;
            tmr        <= '0;
            entry_gate <= 1'b0;
            exit_gate  <= 1'b0;
            deny       <= 1'b0;
        end else begin
            if (tbl_wr) begin
                slot_valid[free_idx] <= 1'b1;
                slot_tok[free_idx]   <= gen;
                token_code           <= gen;
                occupancy            <= occupancy + OCC_W'(1);
            end else if (tbl_clr) begin
                slot_valid[exit_idx] <= 1'b0;
                occupancy            <= occupancy - OCC_W'(1);
            end
            if (gen_inc) gen <= gen_next;
            if (tmr_load)
                tmr <= TMR_W'(GATE_CYCLES - 1);
            else if (tmr != '0)
                tmr <= tmr - TMR_W'(1);
            entry_gate <= (next_state == ENTRY_OPEN);
            exit_gate  <= (next_state == EXIT_OPEN);
            deny       <= (next_state == DENY);
        end
    end

endmodule

// File: tb/tb_park_lane_ctrl.sv
// Directed bench for park_lane_ctrl with CAPACITY=2, DB_CYCLES=4, GATE_CYCLES=3.
module tb_park_lane_ctrl;

    localparam int unsigned TOKEN_W = 5;
    localparam logic [2:0] S_IDLE = 3'd0, S_EC = 3'd1, S_EO = 3'd2,
                           S_XC = 3'd3, S_XO = 3'd4, S_DENY = 3'd5;

    logic               clk_50MHz = 1'b0;
    logic               reset = 1'b1;
    logic               entry_sensor = 1'b0, exit_sensor = 1'b0;
    logic               entry_btn_raw = 1'b0, exit_btn_raw = 1'b0;
    logic [TOKEN_W-1:0] token_input = '0;
    logic [2:0]         state;
    logic [TOKEN_W-1:0] token_code;
    logic [1:0]         occupancy;
    logic               full, empty, entry_gate, exit_gate, deny;

    int checks = 0;
    int errors = 0;
    int ec_cyc = 0, deny_cyc = 0, eg_cyc = 0, overlap_cyc = 0;
    int base_ec, base_deny, base_eg;

    park_lane_ctrl #(
        .CAPACITY(2), .TOKEN_W(TOKEN_W), .DB_CYCLES(4), .GATE_CYCLES(3)
    ) dut (
        .clk_50MHz(clk_50MHz), .reset(reset),
        .entry_sensor(entry_sensor), .exit_sensor(exit_sensor),
        .entry_btn_raw(entry_btn_raw), .exit_btn_raw(exit_btn_raw),
        .token_input(token_input), .state(state), .token_code(token_code),
        .occupancy(occupancy), .full(full), .empty(empty),
        .entry_gate(entry_gate), .exit_gate(exit_gate), .deny(deny)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    // Activity counters sampled on the falling edge
    always @(negedge clk_50MHz) begin
        if (state == S_EC)            ec_cyc      <= ec_cyc + 1;
        if (deny)                     deny_cyc    <= deny_cyc + 1;
        if (entry_gate)               eg_cyc      <= eg_cyc + 1;
        if (entry_gate && exit_gate)  overlap_cyc <= overlap_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_50MHz);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] target, input int budget, input string tag);
        for (int i = 0; i < budget && state !== target; i++) tick();
        chk(tag, 32'(state), 32'(target));
    endtask

    task automatic press_btn(input bit is_exit, input int len);
        if (is_exit) exit_btn_raw = 1'b1; else entry_btn_raw = 1'b1;
        repeat (len) tick();
        exit_btn_raw  = 1'b0;
        entry_btn_raw = 1'b0;
    endtask

    task automatic do_entry(input logic [TOKEN_W-1:0] tok, input string tag);
        entry_sensor = 1'b1;
        press_btn(1'b0, 6);
        wait_state(S_EO, 30, {tag, "_open"});
        chk({tag, "_tok"}, 32'(token_code), 32'(tok));
        entry_sensor = 1'b0;
        wait_state(S_IDLE, 20, {tag, "_idle"});
    endtask

    task automatic do_exit(input logic [TOKEN_W-1:0] tok, input string tag);
        exit_sensor = 1'b1;
        token_input = tok;
        press_btn(1'b1, 6);
        wait_state(S_XO, 30, {tag, "_open"});
        exit_sensor = 1'b0;
        wait_state(S_IDLE, 20, {tag, "_idle"});
    endtask

    task automatic expect_deny(input bit is_exit, input string tag);
        base_deny = deny_cyc;
        press_btn(is_exit, 6);
        repeat (14) tick();
        chk({tag, "_deny_cycles"}, 32'(deny_cyc - base_deny), 32'd3);
        chk({tag, "_state"}, 32'(state), 32'(S_IDLE));
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_tok", 32'(token_code), 32'd0);
        chk("rst_flags", 32'({empty, full, entry_gate, exit_gate, deny}), 32'b10000);

        // Held entry button: one issue, gate held while sensor high
        base_ec = ec_cyc;
        base_eg = eg_cyc;
        entry_sensor = 1'b1;
        press_btn(1'b0, 10);
        repeat (5) tick();
        chk("entry_gate_held", 32'(entry_gate), 32'd1);
        chk("entry_tok", 32'(token_code), 32'd1);
        chk("entry_occ", 32'(occupancy), 32'd1);
        chk("entry_empty", 32'(empty), 32'd0);
        entry_sensor = 1'b0;
        wait_state(S_IDLE, 20, "entry_idle");
        repeat (10) tick();
        chk("entry_one_pulse", 32'(ec_cyc - base_ec), 32'd1);
        chk("entry_gate_min", 32'(eg_cyc - base_eg >= 3), 32'd1);

        // Exit with token 1
        exit_sensor = 1'b1;
        token_input = 5'd1;
        press_btn(1'b1, 6);
        wait_state(S_XO, 30, "exit_open");
        chk("exit_gate", 32'(exit_gate), 32'd1);
        chk("exit_entry_gate", 32'(entry_gate), 32'd0);
        chk("exit_occ", 32'(occupancy), 32'd0);
        chk("exit_empty", 32'(empty), 32'd1);
        exit_sensor = 1'b0;
        wait_state(S_IDLE, 20, "exit_idle");

        // Full lot after reset: tokens 1 and 2, then a denied entry
        reset = 1'b1;
        tick();
        reset = 1'b0;
        do_entry(5'd1, "full_e1");
        do_entry(5'd2, "full_e2");
        chk("full_occ", 32'(occupancy), 32'd2);
        chk("full_flag", 32'(full), 32'd1);
        entry_sensor = 1'b1;
        expect_deny(1'b0, "full3");
        entry_sensor = 1'b0;
        chk("full3_occ", 32'(occupancy), 32'd2);

        // Unknown token and zero token are refused
        exit_sensor = 1'b1;
        token_input = 5'd7;
        expect_deny(1'b1, "bad7");
        chk("bad7_occ", 32'(occupancy), 32'd2);
        token_input = 5'd0;
        expect_deny(1'b1, "bad0");
        exit_sensor = 1'b0;
        chk("bad0_occ", 32'(occupancy), 32'd2);

        // Entry press with sensor low is ignored
        base_ec = ec_cyc;
        base_deny = deny_cyc;
        press_btn(1'b0, 6);
        repeat (10) tick();
        chk("nosensor_ec", 32'(ec_cyc - base_ec), 32'd0);
        chk("nosensor_deny", 32'(deny_cyc - base_deny), 32'd0);

        // Simultaneous presses: exit wins, entry dropped
        base_ec = ec_cyc;
        entry_sensor = 1'b1;
        exit_sensor  = 1'b1;
        token_input  = 5'd1;
        entry_btn_raw = 1'b1;
        press_btn(1'b1, 6);
        wait_state(S_XO, 30, "both_exit_open");
        entry_sensor = 1'b0;
        exit_sensor  = 1'b0;
        wait_state(S_IDLE, 20, "both_idle");
        repeat (10) tick();
        chk("both_no_entry", 32'(ec_cyc - base_ec), 32'd0);
        chk("both_occ", 32'(occupancy), 32'd1);
        do_exit(5'd2, "exit2");
        chk("exit2_occ", 32'(occupancy), 32'd0);

        // Glitch rejection after reset, then generator wrap with token 1 still parked
        reset = 1'b1;
        tick();
        reset = 1'b0;
        base_ec = ec_cyc;
        entry_sensor = 1'b1;
        press_btn(1'b0, 2);
        repeat (15) tick();
        chk("glitch_ec", 32'(ec_cyc - base_ec), 32'd0);
        chk("glitch_state", 32'(state), 32'(S_IDLE));
        do_entry(5'd1, "wrap_e1");
        for (int k = 2; k < 32; k++) begin
            do_entry(TOKEN_W'(k), "cyc_e");
            do_exit(TOKEN_W'(k), "cyc_x");
        end
        base_ec = ec_cyc;
        do_entry(5'd2, "skip");
        chk("skip_ec_cycles", 32'(ec_cyc - base_ec), 32'd2);
        chk("skip_occ", 32'(occupancy), 32'd2);

        // Reset while the entry gate is open
        reset = 1'b1;
        tick();
        reset = 1'b0;
        entry_sensor = 1'b1;
        press_btn(1'b0, 6);
        wait_state(S_EO, 30, "midrst_open");
        chk("midrst_gate_before", 32'(entry_gate), 32'd1);
        reset = 1'b1;
        tick();
        chk("midrst_state", 32'(state), 32'(S_IDLE));
        chk("midrst_gate", 32'(entry_gate), 32'd0);
        chk("midrst_occ", 32'(occupancy), 32'd0);
        chk("midrst_tok", 32'(token_code), 32'd0);
        chk("midrst_empty", 32'(empty), 32'd1);
        reset = 1'b0;

        // First press after reset needs the whole debounce window
        base_ec = ec_cyc;
        press_btn(1'b0, 3);
        repeat (10) tick();
        chk("postrst_short", 32'(ec_cyc - base_ec), 32'd0);
        entry_sensor = 1'b0;

        chk("gate_overlap", 32'(overlap_cyc), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
